// File: rtl/caminho_dados_multiciclo_if.sv
// Unified memory bus of the multicycle datapath: one request outstanding at a
// time, completed in the cycle the memory raises mem_pronto.
interface caminho_dados_multiciclo_if #(
  parameter int LARGURA_DADOS = 32
);
  logic                     mem_req;
  logic                     mem_escrever;
  logic [LARGURA_DADOS-1:0] mem_endereco;
  logic [LARGURA_DADOS-1:0] mem_dados_escrita;
  logic                     mem_pronto;
  logic [LARGURA_DADOS-1:0] mem_dados_leitura;

  modport master (
    output mem_req, mem_escrever, mem_endereco, mem_dados_escrita,
    input  mem_pronto, mem_dados_leitura
  );

  modport slave (
    input  mem_req, mem_escrever, mem_endereco, mem_dados_escrita,
    output mem_pronto, mem_dados_leitura
  );
endinterface

// File: rtl/caminho_dados_multiciclo.sv
// Multicycle RV32-subset datapath (add/sub/and/or/srl/addi/lw/sw/beq/bne)
// sharing one memory port between instruction fetch and data access.
module caminho_dados_multiciclo #(
  parameter int                       LARGURA_DADOS     = 32,
  parameter int                       NUM_REGISTRADORES = 32,
  parameter logic [LARGURA_DADOS-1:0] PC_INICIAL        = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  caminho_dados_multiciclo_if.master mem,
  output logic [LARGURA_DADOS-1:0]   pc_saida,
  output logic [31:0]                instrucao_saida,
  output logic [2:0]                 estado_saida,
  output logic                       parado,
  output logic [31:0]                instrucoes_retiradas
);
  localparam int IDX_W = $clog2(NUM_REGISTRADORES);
  localparam int SH_W  = $clog2(LARGURA_DADOS);
  localparam logic [LARGURA_DADOS-1:0] QUATRO = LARGURA_DADOS'(4);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    MEMORIA    = 3'd3,
    ESCRITA    = 3'd4,
    PARADO     = 3'd5
  } estado_t;

  estado_t                  estado_r, prox_estado_s;
  logic [LARGURA_DADOS-1:0] pc_r, a_r, b_r, res_r, alvo_r;
  logic [31:0]              ir_r, retiradas_r;
  logic [LARGURA_DADOS-1:0] banco_r [NUM_REGISTRADORES];

  logic [6:0]               opcode_s, funct7_s;
  logic [2:0]               funct3_s;
  logic [IDX_W-1:0]         rd_s, rs1_s, rs2_s;
  logic [LARGURA_DADOS-1:0] imm_i_s, imm_s_s, imm_b_s;
  logic [LARGURA_DADOS-1:0] le_rs1_s, le_rs2_s, alu_s;
  logic                     e_alu_r_s, e_addi_s, e_lw_s, e_sw_s, e_desvio_s;
  logic                     legal_s, toma_desvio_s, retira_s;

  assign opcode_s = ir_r[6:0];
  assign funct3_s = ir_r[14:12];
  assign funct7_s = ir_r[31:25];
  assign rd_s     = ir_r[7 +: IDX_W];
  assign rs1_s    = ir_r[15 +: IDX_W];
  assign rs2_s    = ir_r[20 +: IDX_W];
  assign imm_i_s  = {{(LARGURA_DADOS-12){ir_r[31]}}, ir_r[31:20]};
  assign imm_s_s  = {{(LARGURA_DADOS-12){ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
  assign imm_b_s  = {{(LARGURA_DADOS-13){ir_r[31]}}, ir_r[31], ir_r[7],
                     ir_r[30:25], ir_r[11:8], 1'b0};

  // Instruction class decode; anything not matched is illegal and halts.
  always_comb begin
    e_alu_r_s  = 1'b0;
    e_addi_s   = 1'b0;
    e_lw_s     = 1'b0;
    e_sw_s     = 1'b0;
    e_desvio_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        if (funct7_s == 7'b0000000) begin
          e_alu_r_s = (funct3_s == 3'b000) | (funct3_s == 3'b111) |
                      (funct3_s == 3'b110) | (funct3_s == 3'b101);
        end else if (funct7_s == 7'b0100000) begin
          e_alu_r_s = (funct3_s == 3'b000);
        end else begin
          e_alu_r_s = 1'b0;
        end
      end
      OP_IMM:    e_addi_s   = (funct3_s == 3'b000);
      OP_LOAD:   e_lw_s     = (funct3_s == 3'b010);
      OP_STORE:  e_sw_s     = (funct3_s == 3'b010);
      OP_BRANCH: e_desvio_s = (funct3_s == 3'b000) | (funct3_s == 3'b001);
      default:   e_alu_r_s  = 1'b0;
    endcase
  end

  assign legal_s       = e_alu_r_s | e_addi_s | e_lw_s | e_sw_s | e_desvio_s;
  assign toma_desvio_s = funct3_s[0] ? (a_r != b_r) : (a_r == b_r);

  // Register file read ports; x0 is hardwired to zero.
  always_comb begin
    if (rs1_s == '0) begin
      le_rs1_s = '0;
    end else begin
      le_rs1_s = banco_r[rs1_s];
    end
    if (rs2_s == '0) begin
      le_rs2_s = '0;
    end else begin
      le_rs2_s = banco_r[rs2_s];
    end
  end

  // ALU; for lw/sw it produces the effective address.
  always_comb begin
    alu_s = '0;
    case (opcode_s)
      OP_R: begin
        case (funct3_s)
          3'b000: begin
            if (funct7_s[5]) begin
              alu_s = a_r - b_r;
            end else begin
              alu_s = a_r + b_r;
            end
          end
          3'b111:  alu_s = a_r & b_r;
          3'b110:  alu_s = a_r | b_r;
          3'b101:  alu_s = a_r >> b_r[SH_W-1:0];
          default: alu_s = '0;
        endcase
      end
      OP_IMM, OP_LOAD: alu_s = a_r + imm_i_s;
      OP_STORE:        alu_s = a_r + imm_s_s;
      default:         alu_s = '0;
    endcase
  end

  // Next-state logic and retirement strobe.
  always_comb begin
    prox_estado_s = estado_r;
    retira_s      = 1'b0;
    case (estado_r)
      BUSCA: begin
        if (mem.mem_pronto) begin
          prox_estado_s = DECODIFICA;
        end else begin
          prox_estado_s = BUSCA;
        end
      end
      DECODIFICA: begin
        if (legal_s) begin
          prox_estado_s = EXECUTA;
        end else begin
          prox_estado_s = PARADO;
        end
      end
      EXECUTA: begin
        if (e_desvio_s) begin
          prox_estado_s = BUSCA;
          retira_s      = 1'b1;
        end else if (e_lw_s | e_sw_s) begin
          prox_estado_s = MEMORIA;
        end else begin
          prox_estado_s = ESCRITA;
        end
      end
      MEMORIA: begin
        if (!mem.mem_pronto) begin
          prox_estado_s = MEMORIA;
        end else if (e_lw_s) begin
          prox_estado_s = ESCRITA;
        end else begin
          prox_estado_s = BUSCA;
          retira_s      = 1'b1;
        end
      end
      ESCRITA: begin
        prox_estado_s = BUSCA;
        retira_s      = 1'b1;
      end
      PARADO:  prox_estado_s = PARADO;
      default: prox_estado_s = BUSCA;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_r <= BUSCA;
    end else begin
      estado_r <= prox_estado_s;
    end
  end

  // PC, instruction, operand/result registers and retirement counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r        <= PC_INICIAL;
      ir_r        <= 32'd0;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      alvo_r      <= '0;
      retiradas_r <= 32'd0;
    end else begin
      case (estado_r)
        BUSCA: if (mem.mem_pronto) ir_r <= mem.mem_dados_leitura[31:0];
        DECODIFICA: begin
          a_r    <= le_rs1_s;
          b_r    <= le_rs2_s;
          alvo_r <= pc_r + imm_b_s;
        end
        EXECUTA: begin
          res_r <= alu_s;
          if (e_desvio_s) pc_r <= toma_desvio_s ? alvo_r : pc_r + QUATRO;
        end
        MEMORIA: begin
          if (mem.mem_pronto) begin
            if (e_lw_s) res_r <= mem.mem_dados_leitura;
            else        pc_r  <= pc_r + QUATRO;
          end
        end
        ESCRITA: pc_r <= pc_r + QUATRO;
        default: pc_r <= pc_r;
      endcase
      if (retira_s) retiradas_r <= retiradas_r + 32'd1;
    end
  end

  // Register file write port; res_r carries either the ALU result or load data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGISTRADORES; i++) banco_r[i] <= '0;
    end else if ((estado_r == ESCRITA) && (rd_s != '0)) begin
      banco_r[rd_s] <= res_r;
    end
  end

  // Request lines are masked by reset so nothing is requested while it is held.
  assign mem.mem_req           = reset & ((estado_r == BUSCA) | (estado_r == MEMORIA));
  assign mem.mem_escrever      = reset & (estado_r == MEMORIA) & e_sw_s;
  assign mem.mem_endereco      = (estado_r == MEMORIA) ? res_r : pc_r;
  assign mem.mem_dados_escrita = b_r;

  assign pc_saida             = pc_r;
  assign instrucao_saida      = ir_r;
  assign estado_saida         = estado_r;
  assign parado               = (estado_r == PARADO);
  assign instrucoes_retiradas = retiradas_r;
endmodule
